// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard-unit state and the rule that wins priority each cycle.
package cpu_types_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned LCNT_W = 3;
  localparam int unsigned PERF_W = 32;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  // Which hazard rule controls the pipeline in the current cycle
  typedef enum logic [2:0] {
    R_IDLE     = 3'd0,
    R_HALT     = 3'd1,
    R_DMEM     = 3'd2,
    R_REDIRECT = 3'd3,
    R_LOAD     = 3'd4,
    R_IMEM     = 3'd5,
    R_HALTED   = 3'd6
  } hazard_rule_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: decoded stage fields in, pipeline enables/flushes out.
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_unit_if;
  import cpu_types_pkg::*;

  regbits_t rs_id;
  regbits_t rt_id;
  regbits_t regSel_ex;
  logic     regWrite_ex;
  logic     memRead_ex;
  logic     dmemREN_mem;
  logic     dmemWEN_mem;
  logic     dhit;
  logic     ihit;
  logic     redirect_mem;
  logic     halt_wb;

  logic     pc_en;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     halted;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_load_cnt;
  logic [PERF_W-1:0] stall_dmem_cnt;
  logic [PERF_W-1:0] stall_imem_cnt;
  logic [PERF_W-1:0] flush_cnt;
`endif

  modport hu (
    input  rs_id, rt_id, regSel_ex, regWrite_ex, memRead_ex,
    input  dmemREN_mem, dmemWEN_mem, dhit, ihit, redirect_mem, halt_wb,
`ifdef HAZARD_PERF_EN
    output stall_load_cnt, stall_dmem_cnt, stall_imem_cnt, flush_cnt,
`endif
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, halted
  );

  modport tb (
    output rs_id, rt_id, regSel_ex, regWrite_ex, memRead_ex,
    output dmemREN_mem, dmemWEN_mem, dhit, ihit, redirect_mem, halt_wb,
`ifdef HAZARD_PERF_EN
    input  stall_load_cnt, stall_dmem_cnt, stall_imem_cnt, flush_cnt,
`endif
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, halted
  );

endinterface

// File: rtl/hazard_unit.sv
// Pipeline stall/flush control for the 5-stage datapath (load-use, cache waits, redirects, halt).
// Optional HAZARD_PERF_EN adds per-rule cycle counters.
module hazard_unit import cpu_types_pkg::*; #(
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic      CLK,
  input  logic      nRST,
  hazard_unit_if.hu hif
);

  localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_STALL_CYCLES - 1);

  hazard_state_t     state, state_nx;
  logic [LCNT_W-1:0] lcnt, lcnt_nx;
  hazard_rule_t      rule;
  logic              dmem_busy;
  logic              load_use;

  assign dmem_busy = (hif.dmemREN_mem | hif.dmemWEN_mem) & ~hif.dhit;
  assign load_use  = hif.memRead_ex & hif.regWrite_ex & (hif.regSel_ex != '0) &
                     ((hif.regSel_ex == hif.rs_id) | (hif.regSel_ex == hif.rt_id));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      lcnt  <= '0;
    end else begin
      state <= state_nx;
      lcnt  <= lcnt_nx;
    end
  end

  // Priority resolution and next state
  always_comb begin
    state_nx = state;
    lcnt_nx  = lcnt;
    rule     = R_IDLE;
    case (state)
      HALTED: rule = R_HALTED;
      default: begin
        if (hif.halt_wb) begin
          rule     = R_HALT;
          state_nx = HALTED;
          lcnt_nx  = '0;
        end else if (dmem_busy) begin
          rule = R_DMEM;
        end else if (hif.redirect_mem) begin
          rule     = R_REDIRECT;
          state_nx = RUN;
          lcnt_nx  = '0;
        end else if (state == LSTALL) begin
          rule    = R_LOAD;
          lcnt_nx = lcnt - LCNT_W'(1);
          if (lcnt == LCNT_W'(1)) state_nx = RUN;
        end else if (load_use) begin
          rule = R_LOAD;
          if (LOAD_STALL_CYCLES > 1) begin
            state_nx = LSTALL;
            lcnt_nx  = LCNT_INIT;
          end
        end else if (!hif.ihit) begin
          rule = R_IMEM;
        end
      end
    endcase
  end

  // Mealy outputs from the winning rule
  always_comb begin
    hif.pc_en       = 1'b1;
    hif.ifid_en     = 1'b1;
    hif.idex_en     = 1'b1;
    hif.exmem_en    = 1'b1;
    hif.memwb_en    = 1'b1;
    hif.ifid_flush  = 1'b0;
    hif.idex_flush  = 1'b0;
    hif.exmem_flush = 1'b0;
    hif.halted      = 1'b0;
    case (rule)
      R_HALT, R_HALTED, R_DMEM: begin
        hif.pc_en    = 1'b0;
        hif.ifid_en  = 1'b0;
        hif.idex_en  = 1'b0;
        hif.exmem_en = 1'b0;
        hif.memwb_en = 1'b0;
        hif.halted   = (rule != R_DMEM);
      end
      R_REDIRECT: begin
        hif.ifid_flush  = 1'b1;
        hif.idex_flush  = 1'b1;
        hif.exmem_flush = 1'b1;
      end
      R_LOAD: begin
        hif.pc_en      = 1'b0;
        hif.ifid_en    = 1'b0;
        hif.idex_flush = 1'b1;
      end
      R_IMEM: begin
        hif.pc_en      = 1'b0;
        hif.ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] ld_cnt, dm_cnt, im_cnt, fl_cnt;

  // R_HALTED is never counted, so the counters freeze once halted
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ld_cnt <= '0;
      dm_cnt <= '0;
      im_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (rule == R_LOAD)     ld_cnt <= ld_cnt + PERF_W'(1);
      if (rule == R_DMEM)     dm_cnt <= dm_cnt + PERF_W'(1);
      if (rule == R_IMEM)     im_cnt <= im_cnt + PERF_W'(1);
      if (rule == R_REDIRECT) fl_cnt <= fl_cnt + PERF_W'(1);
    end
  end

  assign hif.stall_load_cnt = ld_cnt;
  assign hif.stall_dmem_cnt = dm_cnt;
  assign hif.stall_imem_cnt = im_cnt;
  assign hif.flush_cnt      = fl_cnt;
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage datapath. It generates per-stage pipeline-register enables and flushes, plus PC enable.
- It covers the cases operand forwarding cannot resolve: load-use dependencies, cache-miss waits, taken-branch/jump redirects and halt.
- It is the stall/flush counterpart to operand forwarding.
- Sits beside the datapath; consumes decoded stage fields and cache hit signals.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..7).
- REG_W, 5, register index width.

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- rs_id  input  REG_W  source register A of instruction in ID
- rt_id  input  REG_W  source register B of instruction in ID
- regSel_ex  input  REG_W  destination register of instruction in EX
- regWrite_ex  input  1  EX instruction writes a register
- memRead_ex  input  1  EX instruction is a load
- dmemREN_mem  input  1  MEM-stage data read request
- dmemWEN_mem  input  1  MEM-stage data write request
- dhit  input  1  data cache completes MEM request this cycle
- ihit  input  1  instruction cache returns fetch this cycle
- redirect_mem  input  1  taken branch or jump resolved in MEM
- halt_wb  input  1  halt instruction in WB
- pc_en  output  1  PC register update
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage register enables
- ifid_flush, idex_flush, exmem_flush  output  1 each  synchronous clear of stage register (dominates enable)
- halted  output  1  CPU halted (sticky)

Behaviour:
- State register: RUN, LSTALL, HALTED. Down-counter lcnt, width 3.
- Reset (async, nRST=0): state=RUN, lcnt=0.
- Outputs are Mealy: combinational from state and inputs. Defaults are all enables 1, all flushes 0, halted=0.
- dmem_busy = (dmemREN_mem | dmemWEN_mem) & ~dhit.
- load_use = memRead_ex & regWrite_ex & (regSel_ex != 0) & (regSel_ex == rs_id | regSel_ex == rt_id).

RUN priority (highest first):
1. halt_wb:
   - all enables 0.
   - next=HALTED.
2. dmem_busy:
   - all enables 0, no flush.
   - state and lcnt hold.
3. redirect_mem:
   - pc_en=1.
   - ifid_flush=idex_flush=exmem_flush=1.
   - Overrides load_use: the load-use instruction is squashed.
4. load_use:
   - pc_en=0, ifid_en=0, idex_flush=1.
   - If LOAD_STALL_CYCLES>1: next=LSTALL, lcnt=LOAD_STALL_CYCLES-1.
   - If LOAD_STALL_CYCLES=1: no state change.
5. ~ihit:
   - pc_en=0, ifid_flush=1 (bubble into ID); other enables 1.
6. else: defaults.

LSTALL:
- halt_wb behaves as in RUN.
- dmem_busy freezes everything, including lcnt.
- redirect_mem behaves as in RUN and forces next=RUN, lcnt=0.
- Otherwise: pc_en=0, ifid_en=0, idex_flush=1, lcnt decrements; at lcnt==1 next=RUN.

HALTED:
- All enables 0, flushes 0, halted=1.
- Exit only by reset.
- halted also asserts combinationally in the RUN cycle where halt_wb=1.

Boundaries:
- Register 0 never causes a stall.
- Same register on rs and rt yields one stall, not two.
- dhit in the same cycle as a request: no stall.
- Reset mid-LSTALL returns to RUN with no pending bubbles.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds 32-bit outputs stall_load_cnt, stall_dmem_cnt, stall_imem_cnt, flush_cnt.
  - Each counts cycles in which the respective rule (4/LSTALL, 2, 5, 3) wins priority.
  - Counters freeze in HALTED, wrap modulo 2^32, reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg (shared): hazard_state_t enum {RUN, LSTALL, HALTED} and the regbits_t register-index type.
- Interface hazard_unit_if with modports hu (block) and tb.
- No sub-module needed; perf counters are inline under the macro.

Test Plan:
1. Load-use: memRead_ex=1, regWrite_ex=1, regSel_ex=8, rs_id=8, ihit=1 with LOAD_STALL_CYCLES=1.
   - Response: one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle defaults.
   - Repeat with regSel_ex=0: no stall.
2. LOAD_STALL_CYCLES=3, hazard held for 1 cycle.
   - Response: exactly 3 bubble cycles.
   - Assert dmem_busy in the 2nd bubble for 2 cycles: bubbles total 3, all enables 0 during the busy cycles.
3. dmemREN_mem=1, dhit=0 for 4 cycles, then dhit=1.
   - Response: all enables 0 for 4 cycles, then all 1.
4. redirect_mem=1 together with load_use=1.
   - Response: pc_en=1, three flushes=1, idex_flush=1, no LSTALL entry.
5. halt_wb=1 while dmem_busy=1.
   - Response: halted=1, then sticky with enables 0.
   - nRST pulse mid-cycle: immediate RUN, halted=0.
6. With HAZARD_PERF_EN: 2 load stalls + 4 dmem cycles + 1 redirect.
   - Response: counters read 2, 4, 0, 1.
